// File: rtl/ide_rdata_stripe_dispatch.sv
// ide_rdata_stripe_dispatch: pops granted bursts from the IDE read FIFO and
// stripes them sector by sector across four channel write FIFOs (0,1,2,3,0..).
// Ports: clk, RST (sync, active-high), en, ack (registered grant), rd_q (read
//   FIFO data, valid one cycle after rdreq) -> rdreq, wr_data, wrreq[3:0]
//   (one-hot), cur_chan, busy, sector_done, sector_cnt.
// Option: define STRIPE_SECTOR_CNT_EN to build the 32-bit completed-sector
//   counter; otherwise sector_cnt is tied to zero.
module ide_rdata_stripe_dispatch #(
   parameter int DATA_W       = 16,
   parameter int BURST_LEN    = 64,
   parameter int SECTOR_WORDS = 256
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              en,
   input  logic              ack,
   input  logic [DATA_W-1:0] rd_q,
   output logic              rdreq,
   output logic [DATA_W-1:0] wr_data,
   output logic [3:0]        wrreq,
   output logic [1:0]        cur_chan,
   output logic              busy,
   output logic              sector_done,
   output logic [31:0]       sector_cnt
);

   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int SW = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, BURST, FLUSH, HOLD} state_t;

   state_t              state_q, state_d;
   logic [BW-1:0]       burst_cnt_q, burst_cnt_d;
   logic                phase_q, phase_d;
   logic                rdreq_q, rdreq_d;
   logic                busy_q, busy_d;
   logic                p1_vld_q, p1_vld_d;
   logic [1:0]          p1_chan_q, p1_chan_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [3:0]          wrreq_q, wrreq_d;
   logic [SW-1:0]       sec_word_q, sec_word_d;
   logic                sector_done_q, sector_done_d;
   logic [1:0]          cur_chan_q, cur_chan_d;
   logic                sec_last;

   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      phase_d     = phase_q;
      unique case (state_q)
         IDLE: begin
            burst_cnt_d = '0;
            phase_d     = 1'b0;
            if (en && ack) state_d = BURST;
         end
         BURST: begin
            if (burst_cnt_q == BW'(BURST_LEN - 1)) begin
               state_d     = FLUSH;
               burst_cnt_d = '0;
               phase_d     = 1'b0;
            end else begin
               burst_cnt_d = burst_cnt_q + 1'b1;
            end
         end
         // two cycles: the last pop still needs its read and write stages
         FLUSH: begin
            phase_d = ~phase_q;
            if (phase_q) state_d = HOLD;
         end
         // two cycles: usedw lag plus registered ack must settle
         HOLD: begin
            phase_d = ~phase_q;
            if (phase_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rdreq_d = (state_d == BURST);
      busy_d  = (state_d != IDLE);
   end

   // pop -> tag stage -> registered write; sector position counted on writes
   assign sec_last = (sec_word_q == SW'(SECTOR_WORDS - 1));

   always_comb begin
      p1_vld_d      = rdreq_q;
      p1_chan_d     = cur_chan_q;
      wr_data_d     = wr_data_q;
      wrreq_d       = 4'b0000;
      sector_done_d = 1'b0;
      sec_word_d    = sec_word_q;
      cur_chan_d    = cur_chan_q;
      if (p1_vld_q) begin
         wr_data_d     = rd_q;
         wrreq_d       = 4'b0001 << p1_chan_q;
         sector_done_d = sec_last;
         sec_word_d    = sec_last ? '0 : sec_word_q + 1'b1;
      end
      if (sector_done_q) cur_chan_d = cur_chan_q + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q       <= IDLE;
         burst_cnt_q   <= '0;
         phase_q       <= 1'b0;
         rdreq_q       <= 1'b0;
         busy_q        <= 1'b0;
         p1_vld_q      <= 1'b0;
         p1_chan_q     <= 2'd0;
         wr_data_q     <= '0;
         wrreq_q       <= 4'b0000;
         sec_word_q    <= '0;
         sector_done_q <= 1'b0;
         cur_chan_q    <= 2'd0;
      end else begin
         state_q       <= state_d;
         burst_cnt_q   <= burst_cnt_d;
         phase_q       <= phase_d;
         rdreq_q       <= rdreq_d;
         busy_q        <= busy_d;
         p1_vld_q      <= p1_vld_d;
         p1_chan_q     <= p1_chan_d;
         wr_data_q     <= wr_data_d;
         wrreq_q       <= wrreq_d;
         sec_word_q    <= sec_word_d;
         sector_done_q <= sector_done_d;
         cur_chan_q    <= cur_chan_d;
      end
   end

`ifdef STRIPE_SECTOR_CNT_EN
   logic [31:0] sector_cnt_q, sector_cnt_d;

   always_comb begin
      sector_cnt_d = sector_cnt_q;
      if (sector_done_q) sector_cnt_d = sector_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (RST) sector_cnt_q <= '0;
      else     sector_cnt_q <= sector_cnt_d;
   end

   assign sector_cnt = sector_cnt_q;
`else
   assign sector_cnt = 32'd0;
`endif

   assign rdreq       = rdreq_q;
   assign busy        = busy_q;
   assign wr_data     = wr_data_q;
   assign wrreq       = wrreq_q;
   assign sector_done = sector_done_q;
   assign cur_chan    = cur_chan_q;

endmodule

// File: tb/tb_ide_rdata_stripe_dispatch.sv
// tb_ide_rdata_stripe_dispatch: randomized scoreboard bench for the
// read-FIFO to four-channel sector striping dispatcher.
module tb_ide_rdata_stripe_dispatch;

   localparam int DW = 16;
   localparam int BL = 64;
   localparam int SW = 256;

   logic          clk = 1'b0;
   logic          RST;
   logic          en;
   logic          ack;
   logic [DW-1:0] rd_q = '0;
   logic          rdreq;
   logic [DW-1:0] wr_data;
   logic [3:0]    wrreq;
   logic [1:0]    cur_chan;
   logic          busy;
   logic          sector_done;
   logic [31:0]   sector_cnt;

   ide_rdata_stripe_dispatch #(
      .DATA_W(DW), .BURST_LEN(BL), .SECTOR_WORDS(SW)
   ) dut (
      .clk(clk), .RST(RST), .en(en), .ack(ack), .rd_q(rd_q),
      .rdreq(rdreq), .wr_data(wr_data), .wrreq(wrreq),
      .cur_chan(cur_chan), .busy(busy), .sector_done(sector_done),
      .sector_cnt(sector_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    ch;
      logic [DW-1:0] d;
      logic          sd;
   } exp_t;

   exp_t          q[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            idx = 0;
   logic [DW-1:0] fifo_val = '0;

   // read FIFO model (normal mode) plus expectation push on every pop
   always @(posedge clk) begin
      if (RST) begin
         q.delete();
         idx = 0;
      end else if (rdreq) begin
         q.push_back('{ch: 2'((idx / SW) % 4), d: fifo_val,
                       sd: ((idx % SW) == SW - 1)});
         idx++;
      end
      if (rdreq) begin
         rd_q     <= fifo_val;
         fifo_val <= fifo_val + 1'b1;
      end
   end

   int   wcnt[4] = '{0, 0, 0, 0};
   int   n_sec = 0;
   int   n_rise = 0;
   int   run = 0;
   int   cyc = 0;
   int   last_rise = 0;
   bit   have_prev = 0;
   bit   abort = 0;
   bit   chk_period = 0;
   logic rdreq_prev = 1'b0;
   logic ae_prev = 1'b0;
   exp_t e;

   // monitor: compares writes, burst lengths, grant legality, burst period
   always @(negedge clk) begin
      cyc++;
      if (wrreq != 4'b0000) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: wrreq=%b data=%h, none expected",
                     wrreq, wr_data);
         end else begin
            e = q.pop_front();
            if (wrreq !== (4'b0001 << e.ch) || wr_data !== e.d ||
                sector_done !== e.sd) begin
               n_bad++;
               $display("FAIL write: got wrreq=%b data=%h sd=%b, expected wrreq=%b data=%h sd=%b",
                        wrreq, wr_data, sector_done, 4'b0001 << e.ch, e.d, e.sd);
            end
            wcnt[e.ch]++;
            if (e.sd) n_sec++;
         end
      end else if (sector_done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sector_done_without_write: got 1, expected 0");
      end
      if (!chk_period) have_prev = 0;
      if (rdreq && !rdreq_prev) begin
         n_rise++;
         n_cmp++;
         if (!ae_prev) begin
            n_bad++;
            $display("FAIL burst_without_grant: rdreq rose, en&ack before was 0");
         end
         if (chk_period && have_prev) begin
            n_cmp++;
            if (cyc - last_rise != BL + 5) begin
               n_bad++;
               $display("FAIL burst_period: got %0d cycles, expected %0d",
                        cyc - last_rise, BL + 5);
            end
         end
         last_rise = cyc;
         have_prev = 1;
      end
      if (rdreq) run++;
      else if (rdreq_prev) begin
         if (!abort) begin
            n_cmp++;
            if (run != BL) begin
               n_bad++;
               $display("FAIL burst_len: got %0d pops, expected %0d", run, BL);
            end
         end
         abort = 0;
         run = 0;
      end
      if (RST) begin
         if (rdreq) abort = 1;
         for (int i = 0; i < 4; i++) wcnt[i] = 0;
         n_sec = 0;
      end
      rdreq_prev = rdreq;
      ae_prev    = ack && en && !RST;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_rises(input int k, input int budget);
      int target;
      target = n_rise + k;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (n_rise >= target) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_rise: got %0d bursts, expected %0d", n_rise, target);
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!busy) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_idle: busy got 1, expected 0");
   endtask

   function automatic logic [31:0] exp_scnt();
`ifdef STRIPE_SECTOR_CNT_EN
      return 32'(n_sec);
`else
      return 32'd0;
`endif
   endfunction

   int r;

   initial begin
      RST = 1'b1;
      en  = 1'b0;
      ack = 1'b0;
      repeat (3) tick();
      chk("reset_rdreq", rdreq, 0);
      chk("reset_wrreq", wrreq, 0);
      chk("reset_busy", busy, 0);
      chk("reset_chan", cur_chan, 0);
      chk("reset_sdone", sector_done, 0);
      chk("reset_wdata", wr_data, 0);
      chk("reset_scnt", sector_cnt, 0);
      RST = 1'b0;

      // sustained grant: 32 bursts = 8 sectors, two per channel
      chk_period = 1;
      en  = 1'b1;
      ack = 1'b1;
      wait_rises(32, 32 * (BL + 5) + 200);
      en = 1'b0;
      chk_period = 0;
      wait_idle(200);
      for (int c = 0; c < 4; c++) chk("chan_words", wcnt[c], 2 * SW);
      chk("chan_wrap", cur_chan, 0);
      chk("sector_cnt_8", sector_cnt, exp_scnt());
      chk("queue_drained", q.size(), 0);

      // random grant/enable pattern
      for (int i = 0; i < 3000; i++) begin
         ack = ($urandom % 4) != 0;
         en  = ($urandom % 8) != 0;
         tick();
      end
      en  = 1'b0;
      ack = 1'b0;
      wait_idle(200);
      repeat (4) tick();
      chk("rand_drained", q.size(), 0);
      chk("rand_chan", cur_chan, 32'((idx / SW) % 4));
      chk("rand_scnt", sector_cnt, exp_scnt());

      // enable dropped at burst cycle 10
      en  = 1'b1;
      ack = 1'b1;
      wait_rises(1, 200);
      repeat (9) tick();
      en = 1'b0;
      wait_idle(200);
      r = n_rise;
      repeat (20) tick();
      chk("en_drop_no_burst", n_rise, r);
      chk("en_drop_busy", busy, 0);
      chk("en_drop_drained", q.size(), 0);

      // reset at burst cycle 30
      en = 1'b1;
      wait_rises(1, 200);
      repeat (29) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("rst_rdreq", rdreq, 0);
      chk("rst_wrreq", wrreq, 0);
      chk("rst_chan", cur_chan, 0);
      chk("rst_busy", busy, 0);
      chk("rst_scnt", sector_cnt, 0);

      // restart, grant removed after first burst, then resumed
      wait_rises(1, 200);
      ack = 1'b0;
      wait_idle(200);
      r = n_rise;
      repeat (10) tick();
      chk("ack_drop_no_burst", n_rise, r);
      chk("ack_drop_chan", cur_chan, 0);
      chk("ack_drop_words", wcnt[0], BL);
      ack = 1'b1;
      wait_rises(3, 3 * (BL + 5) + 100);
      en = 1'b0;
      wait_idle(200);
      repeat (4) tick();
      chk("restart_ch0_words", wcnt[0], SW);
      chk("restart_ch1_words", wcnt[1], 0);
      chk("restart_chan", cur_chan, 1);
      chk("restart_scnt", sector_cnt, exp_scnt());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
